// File: rtl/led_char_pkg.sv
// Shared constants, case folding and the 4x8 font for the LED character display.
// Glyph word layout: column 0 in bits [31:24] ... column 3 in bits [7:0]; bit0 of a column = top row.
package led_char_pkg;

  localparam int         GLYPH_W    = 4;
  localparam int         GLYPH_H    = 8;
  localparam logic [7:0] FIRST_CHAR = 8'h20;
  localparam logic [7:0] LAST_CHAR  = 8'h5A;
  localparam int         NUM_GLYPHS = 59;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    logic [7:0] r;
    if ((c >= 8'h61) && (c <= 8'h7A)) begin
      r = c - 8'h20;
    end else begin
      r = c;
    end
    return r;
  endfunction

  function automatic logic [7:0] glyph_column(input logic [31:0] g, input logic [1:0] col);
    logic [7:0] r;
    case (col)
      2'd0:    r = g[31:24];
      2'd1:    r = g[23:16];
      2'd2:    r = g[15:8];
      2'd3:    r = g[7:0];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] font_glyph(input logic [5:0] idx);
    logic [31:0] g;
    case (idx)
      6'd0:  g = 32'h00000000; 6'd1:  g = 32'h005F0000; 6'd2:  g = 32'h00070007;
      6'd3:  g = 32'h147F147F; 6'd4:  g = 32'h242A7F12; 6'd5:  g = 32'h23086462;
      6'd6:  g = 32'h36495650; 6'd7:  g = 32'h00070000; 6'd8:  g = 32'h001C2241;
      6'd9:  g = 32'h41221C00; 6'd10: g = 32'h2A1C1C2A; 6'd11: g = 32'h083E0808;
      6'd12: g = 32'h00503000; 6'd13: g = 32'h08080808; 6'd14: g = 32'h00606000;
      6'd15: g = 32'h60180603; 6'd16: g = 32'h3E51453E; 6'd17: g = 32'h00427F40;
      6'd18: g = 32'h62514946; 6'd19: g = 32'h22414936; 6'd20: g = 32'h1814127F;
      6'd21: g = 32'h27454539; 6'd22: g = 32'h3E494930; 6'd23: g = 32'h01710903;
      6'd24: g = 32'h36494936; 6'd25: g = 32'h0649493E; 6'd26: g = 32'h00363600;
      6'd27: g = 32'h00563600; 6'd28: g = 32'h08142241; 6'd29: g = 32'h14141414;
      6'd30: g = 32'h41221408; 6'd31: g = 32'h02510906; 6'd32: g = 32'h3E415D1E;
      6'd33: g = 32'h7E09097E; 6'd34: g = 32'h7F494936; 6'd35: g = 32'h3E414122;
      6'd36: g = 32'h7F41413E; 6'd37: g = 32'h7F494941; 6'd38: g = 32'h7F090901;
      6'd39: g = 32'h3E41497A; 6'd40: g = 32'h7F08087F; 6'd41: g = 32'h417F4100;
      6'd42: g = 32'h2040413F; 6'd43: g = 32'h7F081463; 6'd44: g = 32'h7F404040;
      6'd45: g = 32'h7F06067F; 6'd46: g = 32'h7F04087F; 6'd47: g = 32'h3E41413E;
      6'd48: g = 32'h7F090906; 6'd49: g = 32'h3E41215E; 6'd50: g = 32'h7F091966;
      6'd51: g = 32'h26494932; 6'd52: g = 32'h017F0101; 6'd53: g = 32'h3F40403F;
      6'd54: g = 32'h1F20601F; 6'd55: g = 32'h7F30307F; 6'd56: g = 32'h631C1C63;
      6'd57: g = 32'h07087807; 6'd58: g = 32'h61514D43;
      default: g = 32'h00000000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/led_font_rom.sv
// Registered font lookup: one 8-pixel glyph column per cycle, plus an unsupported-code flag.
module led_font_rom
  import led_char_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_i,
  input  logic [1:0] col_i,
  output logic [7:0] col_bits,
  output logic       unsupported
);

  logic [7:0] col_bits_d, col_bits_q;
  logic       unsup_d, unsup_q;

  // Range check and table lookup.
  always_comb begin
    unsup_d    = (char_i < FIRST_CHAR) || (char_i > LAST_CHAR);
    col_bits_d = 8'h00;
    if (unsup_d) begin
      col_bits_d = 8'h00;
    end else begin
      col_bits_d = glyph_column(font_glyph(6'(char_i - FIRST_CHAR)), col_i);
    end
  end

  // Read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_bits_q <= 8'h00;
      unsup_q    <= 1'b0;
    end else begin
      col_bits_q <= col_bits_d;
      unsup_q    <= unsup_d;
    end
  end

  assign col_bits    = col_bits_q;
  assign unsupported = unsup_q;

endmodule

// File: rtl/led_char_display.sv
// Scrolling column framebuffer fed by (write, char, column) strobes, scanned onto an LED matrix.
// fb[0] is the leftmost column; new columns enter at fb[NUM_COLS-1].
module led_char_display
  import led_char_pkg::*;
#(
  parameter int NUM_COLS = 16,
  parameter int SCAN_DIV = 1000,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write,
  input  logic [7:0]          char_in,
  input  logic [1:0]          column,
  input  logic                clear,
  output logic [NUM_COLS-1:0] led_col_sel,
  output logic [7:0]          led_row,
  output logic [CNT_W-1:0]    glyph_count,
  output logic                bad_char
);

  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_COLS);

  logic [NUM_COLS-1:0][7:0] fb_d, fb_q;
  logic                     s1_valid_d, s1_valid_q;
  logic                     s1_last_d, s1_last_q;
  logic [PS_W-1:0]          prescaler_d, prescaler_q;
  logic [IDX_W-1:0]         scan_idx_d, scan_idx_q;
  logic [NUM_COLS-1:0]      led_col_sel_d, led_col_sel_q;
  logic [7:0]               led_row_d, led_row_q;
  logic [CNT_W-1:0]         glyph_count_d, glyph_count_q;
  logic                     bad_char_d, bad_char_q;
  logic [7:0]               rom_bits;
  logic                     rom_unsup;

  led_font_rom u_rom (
    .clk         (clk),
    .rst         (rst),
    .char_i      (fold_case(char_in)),
    .col_i       (column),
    .col_bits    (rom_bits),
    .unsupported (rom_unsup)
  );

  // Write pipeline, framebuffer scroll, glyph counter and sticky error; clear wins over write.
  always_comb begin
    s1_valid_d    = write & ~clear;
    s1_last_d     = (column == 2'd3);
    fb_d          = fb_q;
    glyph_count_d = glyph_count_q;
    bad_char_d    = bad_char_q;
    if (clear) begin
      fb_d       = '0;
      bad_char_d = 1'b0;
    end else if (s1_valid_q) begin
      fb_d       = {rom_bits, fb_q[NUM_COLS-1:1]};
      bad_char_d = bad_char_q | rom_unsup;
      if (s1_last_q) begin
        glyph_count_d = glyph_count_q + CNT_W'(1);
      end else begin
        glyph_count_d = glyph_count_q;
      end
    end else begin
      fb_d = fb_q;
    end
  end

  // Scan timing; slot 0 of each column is blanked to avoid ghosting.
  always_comb begin
    prescaler_d = prescaler_q + PS_W'(1);
    scan_idx_d  = scan_idx_q;
    if (prescaler_q == PS_W'(SCAN_DIV - 1)) begin
      prescaler_d = '0;
      if (scan_idx_q == IDX_W'(NUM_COLS - 1)) begin
        scan_idx_d = '0;
      end else begin
        scan_idx_d = scan_idx_q + IDX_W'(1);
      end
    end else begin
      scan_idx_d = scan_idx_q;
    end
    led_col_sel_d = NUM_COLS'(1) << scan_idx_q;
    if (prescaler_q == '0) begin
      led_row_d = 8'h00;
    end else begin
      led_row_d = fb_q[scan_idx_q];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_q          <= '0;
      s1_valid_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      prescaler_q   <= '0;
      scan_idx_q    <= '0;
      led_col_sel_q <= '0;
      led_row_q     <= 8'h00;
      glyph_count_q <= '0;
      bad_char_q    <= 1'b0;
    end else begin
      fb_q          <= fb_d;
      s1_valid_q    <= s1_valid_d;
      s1_last_q     <= s1_last_d;
      prescaler_q   <= prescaler_d;
      scan_idx_q    <= scan_idx_d;
      led_col_sel_q <= led_col_sel_d;
      led_row_q     <= led_row_d;
      glyph_count_q <= glyph_count_d;
      bad_char_q    <= bad_char_d;
    end
  end

  assign led_col_sel = led_col_sel_q;
  assign led_row     = led_row_q;
  assign glyph_count = glyph_count_q;
  assign bad_char    = bad_char_q;

endmodule
